imm_extend_pipe: RTL
====================

Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension unit. It generalises the fixed 16-to-32 sign extender: configurable input and output widths, four extension modes, and a valid/ready handshake. A 2-entry skid buffer gives full throughput with registered outputs. It sits between instruction decode and the ALU operand mux in the CPU datapath.

Parameters:
IN_W, 16, width of the immediate field taken from the instruction
OUT_W, 32, width of the extended datapath word; must satisfy OUT_W >= IN_W+2 (elaboration error otherwise)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream has an immediate to present
in_ready  out  1  block can accept an immediate this cycle
in_imm  in  IN_W  raw immediate field
in_mode  in  2  extension mode, sampled with in_imm
out_valid  out  1  out_data holds a valid result
out_ready  in  1  downstream consumes out_data this cycle
out_data  out  OUT_W  extended result

Behaviour:
- Transfer rules: an input transfer occurs on a clk edge when in_valid && in_ready. An output transfer occurs on a clk edge when out_valid && out_ready.
- Mode encoding, computed combinationally on in_imm before registering:
  - 0 SEXT: {(OUT_W-IN_W){imm[IN_W-1]}, imm}
  - 1 ZEXT: {(OUT_W-IN_W){0}, imm}
  - 2 UPPER: imm placed in the top bits, i.e. {imm, (OUT_W-IN_W){0}}
  - 3 SEXT_SHL2: SEXT result shifted left by 2, zeros shifted in (branch word offset). The discarded top 2 bits are sign copies, so nothing is lost.
- Storage: a main register (main_v, main_d) drives out_valid and out_data directly. A skid register (skid_v, skid_d) holds overflow. in_ready = ~skid_v, driven straight from a flop.
- States:
  - EMPTY (main_v=0, skid_v=0)
  - ONE (main_v=1, skid_v=0)
  - FULL (main_v=1, skid_v=1)
- Transitions, where in_x = input transfer and out_x = output transfer:
  - EMPTY: in_x -> ONE, main loads the result.
  - ONE: in_x & ~out_x -> FULL, skid loads the result. in_x & out_x -> ONE, main loads the result. ~in_x & out_x -> EMPTY. Neither -> hold.
  - FULL: in_ready=0, so no in_x. out_x -> ONE, main <= skid, skid_v <= 0. ~out_x -> hold.
- Latency and throughput: a result appears on out_data the cycle after acceptance. Sustained rate is 1 per clk when out_ready is held high.
- Ordering: strict FIFO order; results are never dropped or duplicated.
- Output stability: out_data and out_valid stay stable while out_valid && ~out_ready.
- Reset: while rst_n=0 (asynchronous), main_v=0, skid_v=0, main_d=0, skid_d=0. Hence out_valid=0, out_data=0, in_ready=1.
  - Reset mid-operation discards all held results. No output transfer is reported during reset.
  - The first acceptance can occur on the first clk edge after rst_n rises.
- Data when not valid: out_data keeps its last value when out_valid=0 (no clearing). The bench must not check it then.
- in_mode is captured only on an input transfer. Changes at any other time have no effect.

Decomposition:
- Package imm_ext_pkg: 2-bit mode type with constants MODE_SEXT=0, MODE_ZEXT=1, MODE_UPPER=2, MODE_SEXT_SHL2=3, plus the state encoding constants.
- Sub-module imm_ext_core (purely combinational, parameters IN_W/OUT_W, inputs imm and mode, output ext): instantiated once ahead of the skid buffer, and reusable by the decoder.

Test Plan:
1. Defaults, out_ready=1: in_imm=0xFFF8, mode 0 -> out_data=0xFFFFFFF8. Same imm with mode 1 -> 0x0000FFF8. 0x0007 with mode 0 -> 0x00000007. 0x8000 with mode 0 -> 0xFFFF8000. Each result appears 1 cycle after acceptance.
2. Modes 2/3: 0x8000 with mode 2 -> 0x80000000. 0xFFFE with mode 3 -> 0xFFFFFFF8. 0x1234 with mode 3 -> 0x000048D0.
3. Backpressure: hold out_ready=0 and offer 3 back-to-back values (0x0001, 0x0002, 0x0003). Expect acceptance of the first two, then in_ready=0 and 0x0003 held off. Then out_ready=1 -> outputs 1, 2, 3 in order, none lost.
4. Throughput: stream 100 random imm/mode pairs with out_ready=1. Expect 100 outputs on consecutive cycles matching a reference model.
5. Reset mid-operation: reach FULL, then pulse rst_n low between clk edges. out_valid=0, out_data=0 and in_ready=1 must hold immediately, before any edge, and the held data is never emitted.
6. Alternate parameters IN_W=12, OUT_W=32: 0x800 with mode 0 -> 0xFFFFF800, with mode 2 -> 0x80000000.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipeline: extension modes and
// skid-buffer state encoding (bit0 = main valid, bit1 = skid valid).
`timescale 1ns/1ps
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SEXT      = 2'd0,
    MODE_ZEXT      = 2'd1,
    MODE_UPPER     = 2'd2,
    MODE_SEXT_SHL2 = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  localparam int ST_MAIN_V_BIT = 0;
  localparam int ST_SKID_V_BIT = 1;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign/zero extend, upper placement, or
// sign extend with a word-offset shift. Usable standalone by the decoder.
`timescale 1ns/1ps
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  mode_e            mode,
  output logic [OUT_W-1:0] ext
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  always_comb begin
    ext = sext;
    unique case (mode)
      MODE_SEXT:      ext = sext;
      MODE_ZEXT:      ext = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_UPPER:     ext = {imm, {(OUT_W-IN_W){1'b0}}};
      // top two bits dropped are sign copies since OUT_W >= IN_W+2
      MODE_SEXT_SHL2: ext = sext << 2;
      default:        ext = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with valid/ready handshake; a 2-entry skid
// buffer keeps full throughput while every output and in_ready come from flops.
`timescale 1ns/1ps
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_extend_pipe: OUT_W must be >= IN_W+2");
  end

  state_e           state_q, state_d;
  logic [1:0]       st_raw;
  logic [OUT_W-1:0] main_data_q, main_data_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [OUT_W-1:0] ext;
  logic             in_x, out_x;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm  (in_imm),
    .mode (mode_e'(in_mode)),
    .ext  (ext)
  );

  // valid bits are the state register bits themselves
  assign st_raw    = state_q;
  assign out_valid = st_raw[ST_MAIN_V_BIT];
  assign in_ready  = ~st_raw[ST_SKID_V_BIT];
  assign out_data  = main_data_q;

  assign in_x  = in_valid & in_ready;
  assign out_x = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_x) begin
          state_d     = ST_ONE;
          main_data_d = ext;
        end
      end
      ST_ONE: begin
        if (in_x && !out_x) begin
          state_d     = ST_FULL;
          skid_data_d = ext;
        end else if (in_x && out_x) begin
          main_data_d = ext;
        end else if (out_x) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_x) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule
